// File: rtl/bus_reg_file_pkg.sv
// Shared constants and the strobe-to-operation encoding for the bus register file.
package bus_reg_file_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } reg_op_e;

    // Write beats inc/dec; inc and dec together cancel out to a hold.
    function automatic reg_op_e decode_op(input logic write_n, input logic inc_n, input logic dec_n);
        if (!write_n) return OP_LOAD;
        if (!inc_n && dec_n) return OP_INC;
        if (!dec_n && inc_n) return OP_DEC;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/bus_reg_file_if.sv
// Control strobes and status outputs of the bus register file; the tri-state bus stays a port.
interface bus_reg_file_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]          i_rd_addr;
    logic [AW-1:0]          i_wr_addr;
    logic                   i_read_n;
    logic                   i_write_n;
    logic                   i_inc_n;
    logic                   i_dec_n;
    logic [DEPTH*WIDTH-1:0] o_data;
    logic [DEPTH-1:0]       o_zero;
    logic                   o_carry;

    modport master (
        output i_rd_addr, i_wr_addr, i_read_n, i_write_n, i_inc_n, i_dec_n,
        input  o_data, o_zero, o_carry
    );

    modport slave (
        input  i_rd_addr, i_wr_addr, i_read_n, i_write_n, i_inc_n, i_dec_n,
        output o_data, o_zero, o_carry
    );

endinterface

// File: rtl/bus_reg_cell.sv
// One WIDTH-bit register that can load, increment or decrement; reports wrap/borrow of the pending op.
module bus_reg_cell
    import bus_reg_file_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  reg_op_e          op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] value,
    output logic             carry_out
);

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;

    always_comb begin
        value_next = value_reg;
        carry_out  = 1'b0;
        case (op)
            OP_LOAD: value_next = din;
            OP_INC: begin
                value_next = value_reg + 1'b1;
                carry_out  = &value_reg;
            end
            OP_DEC: begin
                value_next = value_reg - 1'b1;
                carry_out  = ~|value_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg <= RESET_VALUE;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/bus_reg_file.sv
// Bank of DEPTH registers on the shared tri-state CPU data bus with independent read/write
// addresses, per-register inc/dec and a registered wrap/borrow flag.
module bus_reg_file
    import bus_reg_file_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               DEPTH       = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    bus_reg_file_if.slave   ctl,
    inout  wire [WIDTH-1:0] io_bus
);

    localparam int AW = $clog2(DEPTH);

    reg_op_e          op;
    logic [WIDTH-1:0] value [DEPTH];
    reg_op_e          cell_op [DEPTH];
    logic [DEPTH-1:0] cell_hit;
    logic [DEPTH-1:0] cell_carry;
    logic             wr_hit;
    logic [WIDTH-1:0] drive_val;
    logic             drive_en;
    logic             carry_sel;
    logic             carry_reg;
    logic             carry_next;

    assign op = decode_op(ctl.i_write_n, ctl.i_inc_n, ctl.i_dec_n);

    // Out-of-range write addresses match no cell, so the whole update is dropped.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            assign cell_hit[gi] = (ctl.i_wr_addr == AW'(gi));
            assign cell_op[gi]  = cell_hit[gi] ? op : OP_HOLD;

            bus_reg_cell #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_cell (
                .clk       (i_clk),
                .rst       (i_reset),
                .op        (cell_op[gi]),
                .din       (io_bus),
                .value     (value[gi]),
                .carry_out (cell_carry[gi])
            );

            assign ctl.o_data[gi*WIDTH +: WIDTH] = value[gi];
            assign ctl.o_zero[gi]                = (value[gi] == '0);
        end
    endgenerate

    assign wr_hit = |cell_hit;

    // Unmatched read addresses leave drive_val at zero.
    always_comb begin
        drive_val = '0;
        carry_sel = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ctl.i_rd_addr == AW'(k)) drive_val = value[k];
            if (ctl.i_wr_addr == AW'(k)) carry_sel = cell_carry[k];
        end
    end

    assign drive_en = !ctl.i_read_n && !i_reset;
    assign io_bus   = drive_en ? drive_val : {WIDTH{1'bz}};

    always_comb begin
        carry_next = carry_reg;
        if (wr_hit && (op == OP_INC || op == OP_DEC)) begin
            carry_next = carry_sel;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            carry_reg <= 1'b0;
        end else begin
            carry_reg <= carry_next;
        end
    end

    assign ctl.o_carry = carry_reg;

endmodule

// File: tb/tb_bus_reg_file.sv
// Directed checks of bus_reg_file: a DEPTH=4 instance for the main behaviour and a DEPTH=3
// instance for out-of-range addressing.
module tb_bus_reg_file;

    logic       clk;
    logic       rst;
    int         checks;
    int         failures;

    logic       tb_en4;
    logic [7:0] tb_val4;
    wire  [7:0] bus4;
    logic       tb_en3;
    logic [7:0] tb_val3;
    wire  [7:0] bus3;

    bus_reg_file_if #(.WIDTH(8), .DEPTH(4)) if4 ();
    bus_reg_file_if #(.WIDTH(8), .DEPTH(3)) if3 ();

    assign bus4 = tb_en4 ? tb_val4 : 8'hzz;
    assign bus3 = tb_en3 ? tb_val3 : 8'hzz;

    bus_reg_file #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u_dut4 (
        .i_clk   (clk),
        .i_reset (rst),
        .ctl     (if4),
        .io_bus  (bus4)
    );

    bus_reg_file #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) u_dut3 (
        .i_clk   (clk),
        .i_reset (rst),
        .ctl     (if3),
        .io_bus  (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("txn t=%0t rst=%b d4: rd=%0d wr=%0d rwid=%b%b%b%b data=%h c=%b | d3: rd=%0d wr=%0d rwid=%b%b%b%b data=%h c=%b",
                 $time, rst,
                 if4.i_rd_addr, if4.i_wr_addr, if4.i_read_n, if4.i_write_n, if4.i_inc_n, if4.i_dec_n,
                 if4.o_data, if4.o_carry,
                 if3.i_rd_addr, if3.i_wr_addr, if3.i_read_n, if3.i_write_n, if3.i_inc_n, if3.i_dec_n,
                 if3.o_data, if3.o_carry);
    endtask

    task automatic write4(input logic [1:0] addr, input logic [7:0] val);
        tb_en4 = 1'b1;
        tb_val4 = val;
        if4.i_wr_addr = addr;
        if4.i_write_n = 1'b0;
        step();
        if4.i_write_n = 1'b1;
        tb_en4 = 1'b0;
    endtask

    task automatic write3(input logic [1:0] addr, input logic [7:0] val);
        tb_en3 = 1'b1;
        tb_val3 = val;
        if3.i_wr_addr = addr;
        if3.i_write_n = 1'b0;
        step();
        if3.i_write_n = 1'b1;
        tb_en3 = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        tb_en4 = 1'b1;
        tb_val4 = 8'h5A;
        tb_en3 = 1'b0;
        tb_val3 = 8'h00;
        if4.i_rd_addr = '0; if4.i_wr_addr = '0;
        if4.i_read_n = 1'b1; if4.i_write_n = 1'b1; if4.i_inc_n = 1'b1; if4.i_dec_n = 1'b1;
        if3.i_rd_addr = '0; if3.i_wr_addr = '0;
        if3.i_read_n = 1'b1; if3.i_write_n = 1'b1; if3.i_inc_n = 1'b1; if3.i_dec_n = 1'b1;

        // Reset state
        #3;
        check_val("reset_data", 64'(if4.o_data), 64'h0);
        check_val("reset_zero", 64'(if4.o_zero), 64'hF);
        check_val("reset_carry", 64'(if4.o_carry), 64'h0);
        check_val("reset_bus_released", 64'(bus4), 64'h5A);
        @(negedge clk);
        rst = 1'b0;
        tb_en4 = 1'b0;

        // Write then combinational read
        write4(2'd2, 8'hA5);
        check_val("write_r2_data", 64'(if4.o_data), 64'h00A5_0000);
        check_val("write_r2_zero", 64'(if4.o_zero), 64'hB);
        if4.i_rd_addr = 2'd2;
        if4.i_read_n = 1'b0;
        #1;
        check_val("read_r2_bus", 64'(bus4), 64'hA5);
        if4.i_read_n = 1'b1;
        tb_en4 = 1'b1;
        tb_val4 = 8'h00;
        #1;
        check_val("read_release_bus", 64'(bus4), 64'h00);
        tb_en4 = 1'b0;

        // Register-to-register move over the bus, then same-address move
        write4(2'd1, 8'h3C);
        if4.i_rd_addr = 2'd1;
        if4.i_wr_addr = 2'd3;
        if4.i_read_n = 1'b0;
        if4.i_write_n = 1'b0;
        step();
        check_val("move_r1_to_r3", 64'(if4.o_data), 64'h3CA5_3C00);
        if4.i_rd_addr = 2'd2;
        if4.i_wr_addr = 2'd2;
        step();
        check_val("move_same_addr", 64'(if4.o_data), 64'h3CA5_3C00);
        if4.i_read_n = 1'b1;
        if4.i_write_n = 1'b1;

        // Increment through wrap, then decrement through borrow
        write4(2'd0, 8'hFE);
        check_val("pre_inc_carry", 64'(if4.o_carry), 64'h0);
        if4.i_wr_addr = 2'd0;
        if4.i_inc_n = 1'b0;
        step();
        check_val("inc1_val", 64'(if4.o_data[7:0]), 64'hFF);
        check_val("inc1_carry", 64'(if4.o_carry), 64'h0);
        step();
        check_val("inc2_val", 64'(if4.o_data[7:0]), 64'h00);
        check_val("inc2_carry", 64'(if4.o_carry), 64'h1);
        check_val("inc2_zero0", 64'(if4.o_zero[0]), 64'h1);
        step();
        check_val("inc3_val", 64'(if4.o_data[7:0]), 64'h01);
        check_val("inc3_carry", 64'(if4.o_carry), 64'h0);
        if4.i_inc_n = 1'b1;
        if4.i_dec_n = 1'b0;
        step();
        check_val("dec1_val", 64'(if4.o_data[7:0]), 64'h00);
        check_val("dec1_carry", 64'(if4.o_carry), 64'h0);
        step();
        check_val("dec2_val", 64'(if4.o_data[7:0]), 64'hFF);
        check_val("dec2_carry", 64'(if4.o_carry), 64'h1);
        if4.i_dec_n = 1'b1;

        // Write beats inc; inc+dec together hold
        tb_en4 = 1'b1;
        tb_val4 = 8'h10;
        if4.i_wr_addr = 2'd1;
        if4.i_write_n = 1'b0;
        if4.i_inc_n = 1'b0;
        step();
        check_val("write_over_inc_val", 64'(if4.o_data[15:8]), 64'h10);
        check_val("write_over_inc_carry", 64'(if4.o_carry), 64'h1);
        if4.i_write_n = 1'b1;
        tb_en4 = 1'b0;
        if4.i_dec_n = 1'b0;
        step();
        check_val("inc_dec_hold_val", 64'(if4.o_data[15:8]), 64'h10);
        check_val("inc_dec_hold_carry", 64'(if4.o_carry), 64'h1);
        if4.i_inc_n = 1'b1;
        if4.i_dec_n = 1'b1;

        // Asynchronous reset between edges while an increment is pending
        write4(2'd2, 8'h55);
        check_val("r2_loaded", 64'(if4.o_data[23:16]), 64'h55);
        if4.i_wr_addr = 2'd2;
        if4.i_inc_n = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("async_reset_data", 64'(if4.o_data), 64'h0);
        check_val("async_reset_carry", 64'(if4.o_carry), 64'h0);
        #2;
        rst = 1'b0;
        step();
        check_val("post_reset_inc", 64'(if4.o_data), 64'h0001_0000);
        if4.i_inc_n = 1'b1;

        // DEPTH=3: out-of-range write/inc and read
        write3(2'd1, 8'h77);
        check_val("d3_write_r1", 64'(if3.o_data), 64'h00_7700);
        if3.i_wr_addr = 2'd0;
        if3.i_dec_n = 1'b0;
        step();
        check_val("d3_borrow_val", 64'(if3.o_data), 64'h00_77FF);
        check_val("d3_borrow_carry", 64'(if3.o_carry), 64'h1);
        if3.i_dec_n = 1'b1;
        if3.i_wr_addr = 2'd3;
        if3.i_inc_n = 1'b0;
        step();
        check_val("d3_oor_inc_data", 64'(if3.o_data), 64'h00_77FF);
        check_val("d3_oor_inc_carry", 64'(if3.o_carry), 64'h1);
        if3.i_inc_n = 1'b1;
        write3(2'd3, 8'hEE);
        check_val("d3_oor_write_data", 64'(if3.o_data), 64'h00_77FF);
        if3.i_rd_addr = 2'd3;
        if3.i_read_n = 1'b0;
        #1;
        check_val("d3_oor_read_bus", 64'(bus3), 64'h00);
        if3.i_rd_addr = 2'd1;
        #1;
        check_val("d3_read_r1_bus", 64'(bus3), 64'h77);
        if3.i_read_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
